// File: rtl/early_debounce_pkg.sv
// Shared types and sizing helper for the early-detection debouncer.
package early_debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } debounce_state_t;

  // Lockout length in cycles: ceil(delay / period), never less than one.
  function automatic int unsigned lockout_cycles(input int unsigned delay_ns,
                                                 input int unsigned clk_period_ns);
    logic [63:0] n;
    if (clk_period_ns == 0) return 1;
    n = (64'(delay_ns) + 64'(clk_period_ns) - 64'd1) / 64'(clk_period_ns);
    if (n == 64'd0) n = 64'd1;
    return n[31:0];
  endfunction

endpackage

// File: rtl/early_detection_debouncer_sync_2ff.sv
// 1-bit two-stage synchronizer, async active-low reset to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/early_detection_debouncer.sv
// Early-detection debouncer: first edge passes at once, then output is frozen for N cycles.
// Define EARLY_DEBOUNCE_SYNC_EN to put a 2-flop synchronizer in front of the FSM.
module early_detection_debouncer
  import early_debounce_pkg::*;
#(
  parameter int unsigned CLK_PERIOD_NS = 10,
  parameter int unsigned DELAY_NS      = 20_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic debounced_o
);

  localparam int unsigned N      = lockout_cycles(DELAY_NS, CLK_PERIOD_NS);
  localparam int          CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(N - 1);

  logic btn_s;
  logic s;

`ifdef EARLY_DEBOUNCE_SYNC_EN
  sync_2ff u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (btn_i),
    .q_o    (btn_s)
  );
`else
  assign btn_s = btn_i;
`endif

  // Unknown input reads as released so X never reaches the state register.
  assign s = (btn_s === 1'b1);

  debounce_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ZERO;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      ZERO: begin
        if (s) begin
          state_d = WAIT1;
          cnt_d   = RELOAD;
          out_d   = 1'b1;
        end
      end
      ONE: begin
        if (!s) begin
          state_d = WAIT0;
          cnt_d   = RELOAD;
          out_d   = 1'b0;
        end
      end
      WAIT1: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (s) begin
          state_d = ONE;
        end else begin
          state_d = WAIT0;
          cnt_d   = RELOAD;
          out_d   = 1'b0;
        end
      end
      WAIT0: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!s) begin
          state_d = ZERO;
        end else begin
          state_d = WAIT1;
          cnt_d   = RELOAD;
          out_d   = 1'b1;
        end
      end
      default: begin
        state_d = ZERO;
        cnt_d   = '0;
        out_d   = 1'b0;
      end
    endcase
  end

  assign debounced_o = out_q;

endmodule

// File: tb/tb_early_detection_debouncer.sv
// Directed bench for early_detection_debouncer with N = 10 (10 ns clock, 100 ns lockout).
module tb_early_detection_debouncer;
  import early_debounce_pkg::*;

  localparam int unsigned CLK_PERIOD_NS = 10;
  localparam int unsigned DELAY_NS      = 100;
`ifdef EARLY_DEBOUNCE_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic btn;
  logic debounced;

  logic btn_q[$];
  logic exp_q[$];
  int   total = 0;
  int   bad   = 0;

  early_detection_debouncer #(
    .CLK_PERIOD_NS (CLK_PERIOD_NS),
    .DELAY_NS      (DELAY_NS)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .btn_i       (btn),
    .debounced_o (debounced)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver: queue one cycle of input with its expected output
  task automatic push(input logic b, input logic e);
    btn_q.push_back(b);
    exp_q.push_back(e);
  endtask

  // scoreboard: apply each input at a falling edge, check one cycle later
  task automatic run_q(input string tag);
    int i;
    logic e;
    i = 0;
    while (btn_q.size() > 0) begin
      btn = btn_q.pop_front();
      e   = exp_q.pop_front();
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), {31'b0, debounced}, {31'b0, e});
      i++;
    end
  endtask

  initial begin
    int j;
    rst_n = 1'b0;
    btn   = 1'b1;

    // reset held with button pressed
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_hold", {31'b0, debounced}, 32'd0);
    end
    check("rst_state", 32'(dut.state_q), 32'(ZERO));
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) push(1'b1, (i < EXTRA) ? 1'b0 : 1'b1);
    run_q("rst_release");
    for (int i = 0; i < 25; i++) push(1'b0, (i < EXTRA) ? 1'b1 : 1'b0);
    run_q("settle0");

    // bounce suppression on press
    for (int i = 0; i < 30; i++) begin
      j = i - EXTRA;
      push((i < 3) ? 1'b1 : (i < 6) ? 1'b0 : 1'b1, (j < 0) ? 1'b0 : 1'b1);
    end
    run_q("bounce");

    // clean release after a long hold, bounces of period 5
    for (int i = 0; i < 50; i++) push(1'b1, 1'b1);
    for (int i = 0; i < 30; i++) begin
      j = i - EXTRA;
      push((i < 10) && (i % 5 >= 3), (j < 0) ? 1'b1 : 1'b0);
    end
    run_q("release");
    check("release_state", 32'(dut.state_q), 32'(ZERO));

    // short pulse: high for exactly N, toggled down on expiry
    for (int i = 0; i < 30; i++) begin
      j = i - EXTRA;
      push(i < 2, (j < 0) ? 1'b0 : (j < 10));
    end
    run_q("short_pulse");
    check("short_state", 32'(dut.state_q), 32'(ZERO));

    // short release: toggled back up on WAIT0 expiry
    for (int i = 0; i < 25; i++) push(1'b1, (i < EXTRA) ? 1'b0 : 1'b1);
    for (int i = 0; i < 30; i++) begin
      j = i - EXTRA;
      push(i >= 2, (j < 0) ? 1'b1 : (j >= 10));
    end
    run_q("short_gap");
    check("gap_state", 32'(dut.state_q), 32'(ONE));
    for (int i = 0; i < 25; i++) push(1'b0, (i < EXTRA) ? 1'b1 : 1'b0);
    run_q("settle1");

    // reset mid-lockout acts without a clock edge
    for (int i = 0; i < 4 + EXTRA; i++) push(1'b1, (i < EXTRA) ? 1'b0 : 1'b1);
    run_q("pre_abort");
    check("abort_state_pre", 32'(dut.state_q), 32'(WAIT1));
    #2 rst_n = 1'b0;
    #1 check("abort_async", {31'b0, debounced}, 32'd0);
    btn = 1'b0;
    @(negedge clk);
    check("abort_state", 32'(dut.state_q), 32'(ZERO));
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) push(1'b0, 1'b0);
    run_q("post_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/early_detection_debouncer.md
# early_detection_debouncer

Push-button debouncer using early detection: the first edge seen on the button input is passed to the output at once. The output is then frozen for a fixed lockout interval so contact bounce cannot reach it. The block sits between a raw board button pin and synchronous control logic. It gives minimum-latency, glitch-free press and release events.

## Interface
- `CLK_PERIOD_NS`, default 10: clock period in ns, used only to size the lockout.
- `DELAY_NS`, default 20_000_000: lockout duration in ns.
- Lockout length: N = ceil(DELAY_NS / CLK_PERIOD_NS) cycles, with N forced to at least 1.
- `clk_i`, input, 1 bit: clock. All state updates on the rising edge.
- `rst_ni`, input, 1 bit: reset, asynchronous, active-low.
- `btn_i`, input, 1 bit: raw button level.
- `debounced_o`, input/output direction output, 1 bit: debounced level. Registered; no combinational path from `btn_i`.

## Operation
- States: ZERO (stable low), WAIT1 (lockout after rising), ONE (stable high), WAIT0 (lockout after falling).
- `debounced_o` is 1 in WAIT1 and ONE, and 0 in ZERO and WAIT0.
- ZERO: if the sampled button s = 1, go to WAIT1 on the next edge. The output rises on that same edge and the counter loads N-1.
- ONE: if s = 0, go to WAIT0 on the next edge. The output falls on that same edge and the counter loads N-1.
- WAIT1 / WAIT0 while counter ≠ 0: decrement the counter and ignore s completely.
- WAIT1 / WAIT0 when counter = 0 (lockout expiry edge):
  - If s equals the output level, go to ONE / ZERO.
  - Otherwise toggle the output immediately, enter the opposite WAIT state and reload N-1.
- Result: every output level, once entered, is held for at least N cycles.
- Counter width: $clog2(N) bits, at least 1 bit. The counter never wraps; it is only ever reloaded.
- s is `btn_i` directly, or the synchronizer output when the configuration macro below is defined.
- An X on `btn_i` must not propagate into the state register. Treat s as 0 until the input is known (X-safe compare, or the reset value).

## Timing
- Reset values: state ZERO, `debounced_o` = 0, counter = 0, synchronizer flops = 0.
- Reset assertion takes effect immediately (asynchronous). Release is sampled on the next rising edge.
- Asserting reset during a WAIT state aborts the lockout: output 0, state ZERO.
- Latency with the macro undefined: a `btn_i` change set up before edge k appears on `debounced_o` after edge k (1 cycle).
- Minimum output pulse or gap: exactly N cycles.
- Input activity during lockout has no effect, apart from the level s on the expiry edge.

## Configuration
- `EARLY_DEBOUNCE_SYNC_EN`, defined: `btn_i` passes through a 2-flop synchronizer that resets to 0. Input-to-output latency becomes 3 edges.
- `EARLY_DEBOUNCE_SYNC_EN`, undefined: `btn_i` feeds the FSM directly. The caller guarantees a synchronous input. Latency is 1 edge.

## Structure
- Package `early_debounce_pkg` holds:
  - the state enum typedef `debounce_state_t` (ZERO, WAIT1, ONE, WAIT0);
  - a constant function `lockout_cycles(delay_ns, clk_period_ns)` returning N, minimum 1.
- One sub-module, `sync_2ff`: a 1-bit two-stage synchronizer with async active-low reset. It is instantiated only under the macro.

## Test plan
All scenarios use CLK_PERIOD_NS = 10, DELAY_NS = 100 (N = 10) and the macro undefined unless stated.
- **Reset:** hold `rst_ni` = 0 with `btn_i` = 1 for 5 cycles → `debounced_o` = 0 throughout. After release → `debounced_o` = 1 after the first edge.
- **Bounce suppression:** `btn_i` goes 0→1, then toggles every 3 cycles for 9 cycles, then stays 1 → `debounced_o` rises 1 edge after the first rise and stays 1 continuously.
- **Clean release:** `btn_i` held 1 for 50 cycles, then 0 → `debounced_o` falls 1 edge later and stays 0 for at least 10 cycles despite bounces of 5-cycle period.
- **Short pulse:** `btn_i` = 1 for 2 cycles, then 0 → `debounced_o` is high for exactly 10 cycles, then 0, then stable in ZERO.
- **Reset mid-lockout:** assert `rst_ni` = 0 at cycle 4 of WAIT1 → `debounced_o` goes 0 without waiting for a clock edge. After release with `btn_i` = 0, the output stays 0.
- **Macro defined:** repeat the short-pulse scenario → output rises 3 edges after the input rise. The high time is still exactly 10 cycles.
